// File: rtl/controlador_teclado_pkg.sv
// ---------------------------------------------------------------------------
// controlador_teclado_pkg
// Shared definitions for the 4x4 matrix keypad scanner:
//   - estado_t        : scanner FSM state encoding (2-bit)
//   - COL_RESET       : column drive after reset (column 0 driven low)
//   - ROW_IDLE        : row pattern with no key down (pull-ups)
//   - indice_fila     : row pattern (active-low) -> 2-bit row index,
//                       lowest low row wins
//   - indice_columna  : one-hot-low column drive -> 2-bit column index
// ---------------------------------------------------------------------------
package controlador_teclado_pkg;

    typedef enum logic [1:0] {
        ESCANEO   = 2'd0,
        REBOTE    = 2'd1,
        SOSTENIDA = 2'd2
    } estado_t;

    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0] ROW_IDLE  = 4'b1111;

    // Priority encoder on low bits; several rows low resolve to the lowest.
    function automatic logic [1:0] indice_fila(input logic [3:0] filas);
        logic [1:0] idx;
        if (!filas[0])      idx = 2'd0;
        else if (!filas[1]) idx = 2'd1;
        else if (!filas[2]) idx = 2'd2;
        else                idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [1:0] indice_columna(input logic [3:0] col);
        logic [1:0] idx;
        if (!col[0])      idx = 2'd0;
        else if (!col[1]) idx = 2'd1;
        else if (!col[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/divisor_tick_escaneo.sv
// ---------------------------------------------------------------------------
// divisor_tick_escaneo
// Free-running divider producing a one-clock strobe every CLK_HZ/SCAN_HZ
// clocks. The counter restarts from 0 on reset, so the first strobe comes
// CLK_HZ/SCAN_HZ clocks after reset release.
// Ports:
//   i_Reloj  : clock
//   i_Reset  : asynchronous reset, active low
//   o_Tick   : single-cycle strobe
// ---------------------------------------------------------------------------
module divisor_tick_escaneo #(
    parameter int CLK_HZ  = 100000000,
    parameter int SCAN_HZ = 1000
) (
    input  logic i_Reloj,
    input  logic i_Reset,
    output logic o_Tick
);

    localparam int TERM = CLK_HZ / SCAN_HZ - 1;
    localparam int W    = (TERM > 0) ? $clog2(TERM + 1) : 1;
    localparam logic [W-1:0] TERM_W = W'(TERM);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        o_Tick = (cnt_q == TERM_W);
        cnt_d  = o_Tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge i_Reloj or negedge i_Reset) begin
        if (!i_Reset) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/controlador_teclado_matricial.sv
// ---------------------------------------------------------------------------
// controlador_teclado_matricial
// Scanned 4x4 keypad reader. One column is driven low at a time; the rows
// are sampled once per scan tick (at the end of the column period, before
// the column advances), debounced, and the accepted key is reported as
// code = row*4 + col with a one-clock valid strobe.
// Optional build macro KEYPAD_AUTOREPEAT_EN: while a key stays held, the
// strobe is re-issued every REPEAT_TICKS ticks with the same code.
// Ports:
//   i_Reloj       : clock, rising edge
//   i_Reset       : asynchronous reset, active low
//   i_Filas[3:0]  : row lines, active low, asynchronous to i_Reloj
//   o_Columnas    : column drive, active-low one-hot
//   o_Tecla       : code of the last accepted key
//   o_Valida      : one-clock pulse when o_Tecla is (re)issued
//   o_Presionada  : high while a debounced key is held
// ---------------------------------------------------------------------------
module controlador_teclado_matricial
    import controlador_teclado_pkg::*;
#(
    parameter int CLK_HZ         = 100000000,
    parameter int SCAN_HZ        = 1000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_TICKS   = 500
) (
    input  logic       i_Reloj,
    input  logic       i_Reset,
    input  logic [3:0] i_Filas,
    output logic [3:0] o_Columnas,
    output logic [3:0] o_Tecla,
    output logic       o_Valida,
    output logic       o_Presionada
);

    if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 15 || REPEAT_TICKS < 1) begin : g_param_err
        $error("controlador_teclado_matricial: DEBOUNCE_TICKS must be 1..15, REPEAT_TICKS >= 1");
    end

    localparam logic [4:0] DEB_FIN = 5'(DEBOUNCE_TICKS);

    logic tick;

    divisor_tick_escaneo #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ)
    ) u_divisor (
        .i_Reloj (i_Reloj),
        .i_Reset (i_Reset),
        .o_Tick  (tick)
    );

    // Two-flop synchronizer on the asynchronous row lines.
    logic [3:0] filas_s1_q, filas_s2_q;

    always_ff @(posedge i_Reloj or negedge i_Reset) begin
        if (!i_Reset) begin
            filas_s1_q <= ROW_IDLE;
            filas_s2_q <= ROW_IDLE;
        end else begin
            filas_s1_q <= i_Filas;
            filas_s2_q <= filas_s1_q;
        end
    end

    estado_t    estado_q, estado_d;
    logic [3:0] col_q, col_d;
    logic [3:0] patron_q, patron_d;   // row pattern seen when the press was detected
    logic [3:0] cand_q, cand_d;       // candidate key code for that pattern
    logic [3:0] cnt_q, cnt_d;         // debounce counter (press or release)
    logic [3:0] tecla_q, tecla_d;
    logic       valida_q, valida_d;
    logic       presionada_q, presionada_d;
    logic [4:0] cnt_inc;
    logic       cnt_fin;
    logic       filas_libres;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [RW:0] REP_FIN = (RW + 1)'(REPEAT_TICKS);
    logic [RW-1:0] rep_q, rep_d;
    logic [RW:0]   rep_inc;
`endif

    always_comb begin
        estado_d     = estado_q;
        col_d        = col_q;
        patron_d     = patron_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        tecla_d      = tecla_q;
        valida_d     = 1'b0;
        presionada_d = presionada_q;
        cnt_inc      = {1'b0, cnt_q} + 5'd1;
        cnt_fin      = (cnt_inc >= DEB_FIN);
        filas_libres = (filas_s2_q == ROW_IDLE);
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d        = rep_q;
        rep_inc      = {1'b0, rep_q} + 1'b1;
`endif

        if (tick) begin
            unique case (estado_q)
                ESCANEO: begin
                    if (filas_libres) begin
                        col_d = {col_q[2:0], col_q[3]};
                    end else begin
                        // Column stays frozen from here until the key is released.
                        patron_d = filas_s2_q;
                        cand_d   = {indice_fila(filas_s2_q), indice_columna(col_q)};
                        cnt_d    = 4'd1;
                        estado_d = REBOTE;
                    end
                end
                REBOTE: begin
                    if (filas_s2_q == patron_q) begin
                        cnt_d = cnt_inc[3:0];
                        if (cnt_fin) begin
                            tecla_d      = cand_q;
                            valida_d     = 1'b1;
                            presionada_d = 1'b1;
                            cnt_d        = 4'd0;
                            estado_d     = SOSTENIDA;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d        = '0;
`endif
                        end
                    end else begin
                        cnt_d    = 4'd0;
                        estado_d = ESCANEO;
                    end
                end
                SOSTENIDA: begin
                    if (filas_libres) begin
                        if (cnt_fin) begin
                            presionada_d = 1'b0;
                            cnt_d        = 4'd0;
                            estado_d     = ESCANEO;
                        end else begin
                            cnt_d = cnt_inc[3:0];
                        end
                    end else begin
                        // Any low row (even a different key in this column) restarts release count.
                        cnt_d = 4'd0;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (filas_libres) begin
                        rep_d = '0;
                    end else if (rep_inc >= REP_FIN) begin
                        rep_d    = '0;
                        valida_d = 1'b1;
                    end else begin
                        rep_d = rep_inc[RW-1:0];
                    end
`endif
                end
                default: begin
                    estado_d = ESCANEO;
                end
            endcase
        end

        // Guarantees the strobe never stretches over two clocks, even at one clock per tick.
        valida_d = valida_d & ~valida_q;
    end

    always_ff @(posedge i_Reloj or negedge i_Reset) begin
        if (!i_Reset) begin
            estado_q     <= ESCANEO;
            col_q        <= COL_RESET;
            patron_q     <= ROW_IDLE;
            cand_q       <= 4'd0;
            cnt_q        <= 4'd0;
            tecla_q      <= 4'd0;
            valida_q     <= 1'b0;
            presionada_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            col_q        <= col_d;
            patron_q     <= patron_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            tecla_q      <= tecla_d;
            valida_q     <= valida_d;
            presionada_q <= presionada_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge i_Reloj or negedge i_Reset) begin
        if (!i_Reset) rep_q <= '0;
        else          rep_q <= rep_d;
    end
`endif

    assign o_Columnas   = col_q;
    assign o_Tecla      = tecla_q;
    assign o_Valida     = valida_q;
    assign o_Presionada = presionada_q;

endmodule

// File: doc/controlador_teclado_matricial.md
Name: controlador_teclado_matricial

Overview:
- Scanned 4x4 matrix keypad reader: the input-direction counterpart of the multiplexed 7-segment display controller.
- Drives one column low at a time in a ring, reads the four row lines, debounces, and reports a 4-bit key code with a one-cycle valid strobe.
- Sits beside the display controller on the Basys 3; its key code typically feeds the display's data nibbles.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- SCAN_HZ, 1000, column-advance / sample tick rate in Hz; divider terminal count = CLK_HZ/SCAN_HZ - 1.
- DEBOUNCE_TICKS, 4, consecutive identical samples required to accept a press or a release (1..15).
- REPEAT_TICKS, 500, ticks between repeat strobes while held; used only with the optional feature.

Ports:
- i_Reloj  input  1  system clock, all logic on rising edge.
- i_Reset  input  1  reset, asynchronous, active-low (0 = reset).
- i_Filas  input  4  keypad row lines, active-low (external pull-ups); asynchronous to i_Reloj.
- o_Columnas  output  4  column drive, active-low one-hot.
- o_Tecla  output  4  code of the last accepted key.
- o_Valida  output  1  one-cycle pulse when o_Tecla is updated.
- o_Presionada  output  1  level, high while a debounced key is held.

Behaviour:
- Reset values: o_Columnas=4'b1110, o_Tecla=0, o_Valida=0, o_Presionada=0, FSM=ESCANEO, divider=0, debounce counter=0.
- i_Filas passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Tick: a single-cycle strobe every CLK_HZ/SCAN_HZ clocks. Rows are sampled only on a tick.
- Each sample is taken at the end of the current column's period, before any advance, giving one full tick of settle time.
- Code = {row index, column index}, i.e. row*4 + col. If several rows are low, the lowest row index wins. Ghosting is not resolved.
- ESCANEO:
  - On a tick with all rows high: rotate the column left (1110->1101->1011->0111->1110).
  - On a tick with any row low: latch the candidate row/column, set count=1, hold the column, go to REBOTE.
- REBOTE (column frozen), on each tick:
  - Same row pattern as latched: count+1. When count reaches DEBOUNCE_TICKS, load o_Tecla, pulse o_Valida for one clock, set o_Presionada=1, go to SOSTENIDA.
  - Different pattern, including all high: count=0, return to ESCANEO with the column unchanged.
- SOSTENIDA (column frozen), on each tick:
  - All rows high: count+1. At DEBOUNCE_TICKS, clear o_Presionada, count=0, go to ESCANEO.
  - Any row low: count=0.
  - A second key pressed in the same column is ignored until release. Keys in other columns are not visible.
- o_Valida is never high for two consecutive cycles; o_Tecla holds its value between strobes.
- Reset asserted mid-operation: all state returns to reset values immediately. No strobe is issued on reset release.
- Latency: a clean press is accepted within (4 + DEBOUNCE_TICKS) ticks plus 2 clocks of synchronizer delay.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined: in SOSTENIDA a repeat counter runs on ticks while the key stays down. Every REPEAT_TICKS it re-pulses o_Valida with the same o_Tecla. The counter clears on any tick with rows high.
- Undefined: exactly one o_Valida per accepted press. The repeat counter and REPEAT_TICKS logic are absent.

Decomposition:
- Package controlador_teclado_pkg holds:
  - FSM state encoding: ESCANEO, REBOTE, SOSTENIDA (2-bit).
  - COL_RESET = 4'b1110 and ROW_IDLE = 4'b1111.
  - Function mapping a one-hot-low row pattern to a 2-bit row index.
- One sub-module: divisor_tick_escaneo (parameters CLK_HZ, SCAN_HZ; inputs i_Reloj, i_Reset; output o_Tick single-cycle strobe).

Test Plan:
- Sim uses CLK_HZ=1000, SCAN_HZ=100 (10 clocks/tick), DEBOUNCE_TICKS=4, REPEAT_TICKS=8.
- Reset with i_Filas=4'b1111 -> o_Columnas=1110 and all outputs 0; columns then rotate every 10 clocks, wrapping 0111->1110.
- Clean press: hold row 2 low whenever column 1 is driven, for 60 ticks -> exactly one o_Valida, o_Tecla=4'h9, o_Presionada=1. After release, o_Presionada=0 after 4 high ticks.
- Bounce: row toggles each tick for 6 ticks, then stays low -> no o_Valida during the toggling; strobe arrives 4 stable ticks after it settles.
- Rows 1 and 3 low together on column 3 -> o_Tecla=4'h7. Releasing only row 1 while held -> no new strobe.
- Reset pulled low while in SOSTENIDA -> outputs clear asynchronously. After release with the key still down, a fresh debounce is needed before o_Valida.
- With KEYPAD_AUTOREPEAT_EN, hold key 4'hF for 30 ticks -> strobes at acceptance, then every 8 ticks (4 total). Without the macro -> 1 strobe.
